// File: rtl/tap_pkg.sv
// Shared TAP definitions: state encodings and default instruction decode values.
package tap_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PA_DR  = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PA_IR  = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_e;

    localparam logic [1:0] BYPASS_CODE_DEF = 2'b11;
    localparam logic [1:0] EXTEST_CODE_DEF = 2'b00;

endpackage

// File: rtl/tap_fsm.sv
// TAP state register and TMS-driven next-state logic; resets to Test-Logic-Reset.
module tap_fsm
    import tap_pkg::*;
(
    input  logic       tck_i,
    input  logic       trst_i,
    input  logic       tms_i,
    output tap_state_e state_o
);

    tap_state_e state_q, state_d;

    // NOTE: async reset sits in the sensitivity list so TRST wins over any TCK edge;
    // sequential state always uses non-blocking assignments.
    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:    state_d = tms_i ? TLR    : RTI;
            RTI:    state_d = tms_i ? SEL_DR : RTI;
            SEL_DR: state_d = tms_i ? SEL_IR : CAP_DR;
            SEL_IR: state_d = tms_i ? TLR    : CAP_IR;
            CAP_DR: state_d = tms_i ? EX1_DR : SH_DR;
            SH_DR:  state_d = tms_i ? EX1_DR : SH_DR;
            EX1_DR: state_d = tms_i ? UPD_DR : PA_DR;
            PA_DR:  state_d = tms_i ? EX2_DR : PA_DR;
            EX2_DR: state_d = tms_i ? UPD_DR : SH_DR;
            UPD_DR: state_d = tms_i ? SEL_DR : RTI;
            CAP_IR: state_d = tms_i ? EX1_IR : SH_IR;
            SH_IR:  state_d = tms_i ? EX1_IR : SH_IR;
            EX1_IR: state_d = tms_i ? UPD_IR : PA_IR;
            PA_IR:  state_d = tms_i ? EX2_IR : PA_IR;
            EX2_IR: state_d = tms_i ? UPD_IR : SH_IR;
            UPD_IR: state_d = tms_i ? SEL_DR : RTI;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1-style TAP controller: scan strobes, bypass bit, boundary-scan enable
// and falling-edge retimed TDO.
module tap_controller
    import tap_pkg::*;
#(
    parameter logic [1:0] BYPASS_CODE = BYPASS_CODE_DEF,
    parameter logic [1:0] EXTEST_CODE = EXTEST_CODE_DEF
) (
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    input  logic       TDI,
    input  logic [1:0] sel,
    input  logic       tdo_bsr,
    input  logic       tdo_ir,
    output logic       TDO,
    output logic       tdo_en,
    output logic       clockdr,
    output logic       shiftdr,
    output logic       updatedr,
    output logic       clockir,
    output logic       shiftir,
    output logic       updateir,
    output logic       bs_en,
    output logic       test_logic_reset,
    output logic [3:0] state
);

    tap_state_e state_w;

    tap_fsm u_fsm (
        .tck_i  (TCK),
        .trst_i (TRST),
        .tms_i  (TMS),
        .state_o(state_w)
    );

    logic dr_clk_en_q, ir_clk_en_q, shiftdr_q, shiftir_q;
    logic tdo_q, tdo_d, tdo_en_q, tdo_en_d;
    logic bypass_q, bypass_d;

    always_comb begin
        tdo_d    = 1'b0;
        tdo_en_d = 1'b0;
        if (state_w == SH_IR) begin
            tdo_d    = tdo_ir;
            tdo_en_d = 1'b1;
        end else if (state_w == SH_DR) begin
            tdo_d    = (sel == BYPASS_CODE) ? bypass_q : tdo_bsr;
            tdo_en_d = 1'b1;
        end
    end

    // Enables change only while TCK is low, so the TCK-gated strobes cannot glitch.
    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) begin
            dr_clk_en_q <= 1'b0;
            ir_clk_en_q <= 1'b0;
            shiftdr_q   <= 1'b0;
            shiftir_q   <= 1'b0;
            tdo_q       <= 1'b0;
            tdo_en_q    <= 1'b0;
        end else begin
            dr_clk_en_q <= (state_w == CAP_DR) || (state_w == SH_DR);
            ir_clk_en_q <= (state_w == CAP_IR) || (state_w == SH_IR);
            shiftdr_q   <= (state_w == SH_DR);
            shiftir_q   <= (state_w == SH_IR);
            tdo_q       <= tdo_d;
            tdo_en_q    <= tdo_en_d;
        end
    end

    always_comb begin
        bypass_d = bypass_q;
        if (sel == BYPASS_CODE) begin
            if (state_w == CAP_DR) begin
                bypass_d = 1'b0;
            end else if (state_w == SH_DR) begin
                bypass_d = TDI;
            end
        end
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            bypass_q <= 1'b0;
        end else begin
            bypass_q <= bypass_d;
        end
    end

    assign clockdr          = TCK & dr_clk_en_q;
    assign clockir          = TCK & ir_clk_en_q;
    assign updatedr         = ~TCK & (state_w == UPD_DR);
    assign updateir         = ~TCK & (state_w == UPD_IR);
    assign shiftdr          = shiftdr_q;
    assign shiftir          = shiftir_q;
    assign TDO              = tdo_q;
    assign tdo_en           = tdo_en_q;
    assign test_logic_reset = (state_w == TLR);
    assign bs_en            = (sel == EXTEST_CODE) & ~test_logic_reset;
    assign state            = state_w;

endmodule
